// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings for the run/halt sequencer: FSM states, pause causes,
// and the default syscall code that stops the core.
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_PAUSE = 2'd3
    } run_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_SYSCALL = 2'd1,
        CAUSE_BKPT    = 2'd2,
        CAUSE_STEP    = 2'd3
    } pause_cause_e;

    // MARS exit convention: syscall with $v0 == 10 terminates the program.
    localparam logic [31:0] HALT_CODE_DEF = 32'd10;

endpackage

// File: rtl/cpu_run_ctrl_go_sync_edge.sv
// Go push-button conditioning: three-flop synchroniser followed by a
// rising-edge detector producing a single-cycle go_pulse.
module cpu_run_ctrl_go_sync_edge (
    input  logic clk,
    input  logic clr,
    input  logic go,
    output logic go_pulse
);

    logic s1_q, s2_q, s3_q;

    // Shift the raw level through the synchroniser; s3 holds the previous s2
    // so a level held across reset release still yields exactly one pulse.
    always_ff @(posedge clk) begin
        if (!clr) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= go;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign go_pulse = s2_q & ~s3_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt sequencer for the single-cycle MIPS core. Owns the PC register
// enable: run, single-step, syscall halt, one PC breakpoint, and a
// retired-instruction counter.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter logic [31:0] HALT_CODE = HALT_CODE_DEF,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             go,
    input  logic             step_mode,
    input  logic             syscall,
    input  logic [31:0]      syscall_arg,
    input  logic             bkpt_en,
    input  logic [31:0]      bkpt_addr,
    input  logic [31:0]      pc,
    output logic             pc_en,
    output logic [1:0]       run_state,
    output logic [1:0]       pause_cause,
    output logic [CNT_W-1:0] instr_count
);

    run_state_e       state_q;
    pause_cause_e     cause_q;
    logic             resume_q;
    logic [CNT_W-1:0] cnt_q;

    logic go_pulse;
    logic halt_hit;
    logic bkpt_hit;
    logic pc_en_c;

    cpu_run_ctrl_go_sync_edge u_go_sync (
        .clk      (clk),
        .clr      (clr),
        .go       (go),
        .go_pulse (go_pulse)
    );

    assign halt_hit = syscall & (syscall_arg == HALT_CODE);
    assign bkpt_hit = bkpt_en & (pc == bkpt_addr);

    // PC enable: RUN stops on a halt/breakpoint unless we are just resuming
    // past one; STEP always retires its single instruction.
    always_comb begin
        pc_en_c = 1'b0;
        case (state_q)
            ST_RUN:  pc_en_c = resume_q | ~(halt_hit | bkpt_hit);
            ST_STEP: pc_en_c = 1'b1;
            default: pc_en_c = 1'b0;
        endcase
    end

    // Run/halt FSM with registered cause and the resume mask that lets the
    // core step over the instruction it stopped on.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q  <= ST_IDLE;
            cause_q  <= CAUSE_NONE;
            resume_q <= 1'b0;
        end else begin
            if (pc_en_c) resume_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_PAUSE: begin
                    if (go_pulse) begin
                        state_q  <= step_mode ? ST_STEP : ST_RUN;
                        cause_q  <= CAUSE_NONE;
                        resume_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!resume_q && halt_hit) begin
                        state_q <= ST_PAUSE;
                        cause_q <= CAUSE_SYSCALL;
                    end else if (!resume_q && bkpt_hit) begin
                        state_q <= ST_PAUSE;
                        cause_q <= CAUSE_BKPT;
                    end
                end
                ST_STEP: begin
                    state_q <= ST_PAUSE;
                    cause_q <= CAUSE_STEP;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!clr) begin
            cnt_q <= '0;
        end else if (pc_en_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign pc_en       = pc_en_c;
    assign run_state   = state_q;
    assign pause_cause = cause_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl. A tiny PC model advances by 4 whenever
// pc_en was high at an edge (optionally looping back), and drives syscall
// from a programmed syscall PC. A second instance with CNT_W=4 checks wrap.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        clr, go, step_mode, syscall, bkpt_en;
    logic [31:0] syscall_arg, bkpt_addr, pc;
    logic        pc_en, pc_en4;
    logic [1:0]  run_state, pause_cause, run_state4, pause_cause4;
    logic [31:0] instr_count;
    logic [3:0]  instr_count4;

    logic [31:0] sys_pc, sys_arg, loop_end, loop_to;
    int nchk  = 0;
    int nfail = 0;

    localparam logic [31:0] NOWHERE = 32'hFFFF_FFFC;

    always #5 clk = ~clk;

    cpu_run_ctrl dut (
        .clk(clk), .clr(clr), .go(go), .step_mode(step_mode),
        .syscall(syscall), .syscall_arg(syscall_arg),
        .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr), .pc(pc),
        .pc_en(pc_en), .run_state(run_state), .pause_cause(pause_cause),
        .instr_count(instr_count)
    );

    cpu_run_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .clr(clr), .go(go), .step_mode(step_mode),
        .syscall(syscall), .syscall_arg(syscall_arg),
        .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr), .pc(pc),
        .pc_en(pc_en4), .run_state(run_state4), .pause_cause(pause_cause4),
        .instr_count(instr_count4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd();
        syscall     = (pc == sys_pc);
        syscall_arg = syscall ? sys_arg : 32'h0;
        #1;
    endtask

    task automatic cyc();
        logic en;
        en = pc_en;
        @(posedge clk); #1;
        if (en) pc = (pc == loop_end) ? loop_to : pc + 32'd4;
        upd();
    endtask

    // Full button press: release long enough to re-arm, then hold until the
    // FSM has taken the pulse (third edge after go rises).
    task automatic press();
        go = 1'b0;
        repeat (3) cyc();
        go = 1'b1;
        repeat (3) cyc();
        go = 1'b0;
    endtask

    task automatic do_reset();
        clr = 1'b0;
        cyc(); cyc();
        clr = 1'b1;
        pc  = 32'h0;
        upd();
    endtask

    task automatic run_to(input string tag, input logic [31:0] target);
        for (int i = 0; i < 200 && pc != target; i++) cyc();
        chk(tag, pc, target);
    endtask

    initial begin
        clr = 1'b0; go = 1'b0; step_mode = 1'b0; bkpt_en = 1'b0;
        bkpt_addr = 32'h0; pc = 32'h0;
        sys_pc = NOWHERE; sys_arg = 32'd10; loop_end = NOWHERE; loop_to = 32'h0;
        upd();
        cyc(); cyc();
        chk("rst_state", run_state, 2'd0);
        chk("rst_cause", pause_cause, 2'd0);
        chk("rst_count", instr_count, 32'd0);
        chk("rst_pc_en", pc_en, 1'b0);

        // 1: synchronised Go -> RUN on the third edge, counter follows.
        clr = 1'b1;
        go  = 1'b1;
        cyc();
        chk("go_e1_idle", run_state, 2'd0);
        cyc();
        chk("go_e2_idle", run_state, 2'd0);
        chk("go_e2_pc_en", pc_en, 1'b0);
        cyc();
        chk("go_e3_run", run_state, 2'd1);
        chk("go_e3_pc_en", pc_en, 1'b1);
        chk("go_e3_count", instr_count, 32'd0);
        cyc();
        chk("cnt1", instr_count, 32'd1);
        cyc();
        chk("cnt2", instr_count, 32'd2);
        go = 1'b0;

        // 2: halting syscall at 0x40, then resume past it.
        sys_pc = 32'h40; sys_arg = 32'd10;
        upd();
        run_to("reach_40", 32'h40);
        chk("sys_pc_en0", pc_en, 1'b0);
        chk("sys_count16", instr_count, 32'd16);
        chk("wrap4_16", instr_count4, 4'd0);
        cyc();
        chk("sys_pause", run_state, 2'd3);
        chk("sys_cause", pause_cause, 2'd1);
        chk("sys_cause4", pause_cause4, 2'd1);
        chk("sys_pc_hold", pc, 32'h40);
        cyc();
        chk("sys_hold2", pc, 32'h40);
        chk("sys_hold_en", pc_en, 1'b0);
        press();
        chk("res_run", run_state, 2'd1);
        chk("res_pc_en", pc_en, 1'b1);
        chk("res_pc_en4", pc_en4, 1'b1);
        chk("res_cause", pause_cause, 2'd0);
        sys_pc = 32'h48; sys_arg = 32'd4;
        cyc();
        chk("res_pc44", pc, 32'h44);
        chk("res_cnt17", instr_count, 32'd17);
        cyc();
        chk("nonhalt_en", pc_en, 1'b1);
        cyc();
        chk("nonhalt_run", run_state, 2'd1);
        chk("nonhalt_cnt", instr_count, 32'd19);

        // 3: breakpoint at 0x20, step past it, loop back re-halts.
        sys_pc = NOWHERE;
        do_reset();
        chk("rst2_count", instr_count, 32'd0);
        bkpt_en = 1'b1; bkpt_addr = 32'h20; loop_end = 32'h28; loop_to = 32'h20;
        press();
        chk("bk_run", run_state, 2'd1);
        run_to("reach_20", 32'h20);
        chk("bk_pc_en0", pc_en, 1'b0);
        cyc();
        chk("bk_pause", run_state, 2'd3);
        chk("bk_cause", pause_cause, 2'd2);
        chk("bk_count", instr_count, 32'd8);
        press();
        chk("bk_res_en", pc_en, 1'b1);
        cyc();
        chk("bk_pc24", pc, 32'h24);
        cyc(); cyc();
        chk("bk_loop_pc", pc, 32'h20);
        chk("bk_loop_en0", pc_en, 1'b0);
        cyc();
        chk("bk_rehalt", run_state, 2'd3);
        chk("bk_rehalt_cause", pause_cause, 2'd2);
        chk("bk_count11", instr_count, 32'd11);

        // 4: single-step, three presses -> three instructions.
        bkpt_en = 1'b0; loop_end = NOWHERE;
        do_reset();
        step_mode = 1'b1;
        press();
        chk("st_state", run_state, 2'd2);
        chk("st_pc_en", pc_en, 1'b1);
        cyc();
        chk("st_pause", run_state, 2'd3);
        chk("st_cause", pause_cause, 2'd3);
        chk("st_pc_en0", pc_en, 1'b0);
        chk("st_pc4", pc, 32'h4);
        press(); cyc();
        press(); cyc();
        cyc();
        chk("st_count3", instr_count, 32'd3);
        chk("st_pcC", pc, 32'hC);
        chk("st_cause3", pause_cause, 2'd3);

        // 5: Go in RUN is ignored; simultaneous syscall+bkpt -> SYSCALL.
        step_mode = 1'b0;
        do_reset();
        bkpt_en = 1'b1; bkpt_addr = 32'h30; sys_pc = 32'h30; sys_arg = 32'd10;
        press();
        press();
        chk("gorun_state", run_state, 2'd1);
        chk("gorun_pc", pc, 32'h18);
        chk("gorun_cnt", instr_count, 32'd6);
        run_to("reach_30", 32'h30);
        chk("both_en0", pc_en, 1'b0);
        cyc();
        chk("both_pause", run_state, 2'd3);
        chk("both_cause", pause_cause, 2'd1);
        chk("both_cnt", instr_count, 32'd12);

        // 6: reset mid-RUN at 0x1234, then go held across reset release.
        bkpt_en = 1'b0; sys_pc = NOWHERE;
        do_reset();
        press();
        for (int i = 0; i < 32'h1234; i++) cyc();
        chk("mid_cnt", instr_count, 32'h1234);
        chk("mid_cnt4", instr_count4, 4'h4);
        clr = 1'b0;
        cyc();
        chk("mid_rst_state", run_state, 2'd0);
        chk("mid_rst_cnt", instr_count, 32'd0);
        chk("mid_rst_en", pc_en, 1'b0);
        chk("mid_rst_cnt4", instr_count4, 4'd0);
        step_mode = 1'b1;
        go = 1'b1;
        cyc();
        clr = 1'b1; pc = 32'h0; upd();
        cyc(); cyc();
        chk("held_idle", run_state, 2'd0);
        cyc();
        chk("held_step", run_state, 2'd2);
        repeat (5) cyc();
        chk("held_pause", run_state, 2'd3);
        chk("held_once", instr_count, 32'd1);
        go = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
